// File: rtl/alu_pkg.sv
// Shared ALU op codes, default widths and the control bundle carried to execute.
package alu_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [4:0] {
    ALU_MOV = 5'b00000,
    ALU_ADD = 5'b00001,
    ALU_SUB = 5'b00010,
    ALU_AND = 5'b00011,
    ALU_OR  = 5'b00100,
    ALU_XOR = 5'b00101,
    ALU_SLL = 5'b00110,
    ALU_SRL = 5'b00111,
    ALU_SRA = 5'b01000,
    ALU_EQ  = 5'b01001,
    ALU_NE  = 5'b01010,
    ALU_LTU = 5'b01011,
    ALU_GTU = 5'b01100,
    ALU_GEU = 5'b01101,
    ALU_LT  = 5'b01110,
    ALU_GT  = 5'b01111,
    ALU_GE  = 5'b10000,
    ALU_LUI = 5'b10001
  } alu_op_e;

  typedef struct packed {
    logic [4:0]            alucontrol;
    logic [DEF_REG_AW-1:0] rd_addr;
    logic                  wb_en;
    logic                  mem_read;
  } op_t;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding: MEM result beats WB result beats register file; r0 is hardwired zero.
module fwd_mux #(
  parameter int AW = 5,
  parameter int W  = 32
) (
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_rf_data,
  input  logic          i_mem_en,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [W-1:0]  i_mem_data,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [W-1:0]  i_wb_data,
  output logic [W-1:0]  o_data,
  output logic          o_mem_hit
);

  logic w_nonzero;
  logic w_wb_hit;

  assign w_nonzero = (i_addr != '0);
  assign o_mem_hit = w_nonzero && i_mem_en && (i_mem_addr == i_addr);
  assign w_wb_hit  = w_nonzero && i_wb_en && (i_wb_addr == i_addr);

  always_comb begin
    o_data = '0;
    if (o_mem_hit)      o_data = i_mem_data;
    else if (w_wb_hit)  o_data = i_wb_data;
    else if (w_nonzero) o_data = i_rf_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand/issue stage ahead of the ALU with MEM/WB forwarding and load-use stall.
// Optional performance counters are built when ALU_OPERAND_PERF_EN is defined.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int XLEN   = DEF_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [4:0]        id_alucontrol,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [XLEN-1:0]   id_rs_data,
  input  logic [XLEN-1:0]   id_rd_data,
  input  logic              id_use_imm,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_fwd_addr,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              mem_fwd_is_load,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_addr,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_srca,
  output logic [XLEN-1:0]   ex_srcb,
  output logic [4:0]        ex_alucontrol,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_wb_en,
  output logic              ex_mem_read
`ifdef ALU_OPERAND_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  logic [XLEN-1:0] w_rs_fwd, w_rd_fwd, w_srca;
  logic            w_rs_mem_hit, w_rd_mem_hit;
  logic            w_hz, w_accept, w_capture;
  logic            r_valid;
  logic [XLEN-1:0] r_srca, r_srcb;
  op_t             r_op;

  fwd_mux #(.AW(REG_AW), .W(XLEN)) u_fwd_rs (
    .i_addr(id_rs_addr), .i_rf_data(id_rs_data),
    .i_mem_en(mem_fwd_en), .i_mem_addr(mem_fwd_addr), .i_mem_data(mem_fwd_data),
    .i_wb_en(wb_fwd_en), .i_wb_addr(wb_fwd_addr), .i_wb_data(wb_fwd_data),
    .o_data(w_rs_fwd), .o_mem_hit(w_rs_mem_hit)
  );

  fwd_mux #(.AW(REG_AW), .W(XLEN)) u_fwd_rd (
    .i_addr(id_rd_addr), .i_rf_data(id_rd_data),
    .i_mem_en(mem_fwd_en), .i_mem_addr(mem_fwd_addr), .i_mem_data(mem_fwd_data),
    .i_wb_en(wb_fwd_en), .i_wb_addr(wb_fwd_addr), .i_wb_data(wb_fwd_data),
    .o_data(w_rd_fwd), .o_mem_hit(w_rd_mem_hit)
  );

  // rs is not a real dependency when the immediate replaces it; rd always feeds srcb.
  assign w_srca    = id_use_imm ? id_imm : w_rs_fwd;
  assign w_hz      = id_valid && mem_fwd_is_load &&
                     ((w_rs_mem_hit && !id_use_imm) || w_rd_mem_hit);
  assign id_ready  = !w_hz && (!r_valid || ex_ready);
  assign w_accept  = id_valid && id_ready;
  assign w_capture = w_accept && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_valid <= 1'b0;
    else if (flush)     r_valid <= 1'b0;
    else if (w_capture) r_valid <= 1'b1;
    else if (ex_ready)  r_valid <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_srca <= '0;
      r_srcb <= '0;
      r_op   <= '0;
    end else if (w_capture) begin
      r_srca <= w_srca;
      r_srcb <= w_rd_fwd;
      r_op   <= '{alucontrol: id_alucontrol, rd_addr: id_rd_addr,
                  wb_en: id_wb_en, mem_read: id_mem_read};
    end
  end

  assign ex_valid      = r_valid;
  assign ex_srca       = r_srca;
  assign ex_srcb       = r_srcb;
  assign ex_alucontrol = r_op.alucontrol;
  assign ex_rd_addr    = r_op.rd_addr;
  assign ex_wb_en      = r_op.wb_en;
  assign ex_mem_read   = r_op.mem_read;

`ifdef ALU_OPERAND_PERF_EN
  logic [31:0] r_stall_cnt, r_bubble_cnt;
  logic        w_stall, w_bubble;

  assign w_stall  = id_valid && !id_ready;
  // A bubble is a slot execute could have taken but the load-use hazard left empty.
  assign w_bubble = w_hz && (!r_valid || ex_ready) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))   r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered issue stage that sits directly upstream of the ALU and feeds it srca, srcb and alucontrol.
- Accepts one decoded operation per cycle from decode (valid/ready).
- Resolves operands by forwarding from the MEM and WB stages, with the register file as fallback.
- Detects load-use hazards and stalls upstream; presents a registered, stable operation to execute (valid/ready).

Parameters:
- REG_AW, 5, register address width (register 0 reads as zero).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  discard held and incoming ops (branch taken).
- id_valid  in  1  decode offers an op.
- id_ready  out  1  stage accepts this cycle.
- id_alucontrol  in  5  ALU op code.
- id_rs_addr  in  REG_AW  source register; produces srca.
- id_rd_addr  in  REG_AW  destination register; also produces srcb.
- id_rs_data  in  XLEN  register file read of rs.
- id_rd_data  in  XLEN  register file read of rd.
- id_use_imm  in  1  srca comes from id_imm instead of rs.
- id_imm  in  XLEN  sign/zero-extended immediate, extended by decode.
- id_wb_en  in  1  op writes rd.
- id_mem_read  in  1  op is a load.
- mem_fwd_en  in  1  MEM stage will write mem_fwd_addr.
- mem_fwd_addr  in  REG_AW  MEM destination.
- mem_fwd_data  in  XLEN  MEM ALU result.
- mem_fwd_is_load  in  1  MEM data not yet available.
- wb_fwd_en  in  1  WB write enable.
- wb_fwd_addr  in  REG_AW  WB destination.
- wb_fwd_data  in  XLEN  WB data.
- ex_valid  out  1  op held for ALU.
- ex_ready  in  1  execute consumes.
- ex_srca  out  XLEN  ALU srca.
- ex_srcb  out  XLEN  ALU srcb.
- ex_alucontrol  out  5  ALU op.
- ex_rd_addr  out  REG_AW  passthrough.
- ex_wb_en  out  1  passthrough.
- ex_mem_read  out  1  passthrough.

Behaviour:
- Reset (async): ex_valid=0; ex_srca, ex_srcb and ex_rd_addr = 0; ex_alucontrol=5'b00000; ex_wb_en=0; ex_mem_read=0.
- Operand resolution, per operand, combinational on id_* signals:
  - Address 0 yields 0 and is never forwarded.
  - Otherwise priority order: MEM match (mem_fwd_en && addr equal) > WB match > register file data.
  - srca uses id_imm when id_use_imm=1; no rs hazard check is made in that case.
  - srcb always comes from rd, even for ops that ignore it.
- Hazard: hz = id_valid && mem_fwd_is_load && mem_fwd_en && MEM address matches a used, nonzero operand address.
- Handshake:
  - id_ready = !hz && (!ex_valid || ex_ready).
  - Capture on id_valid && id_ready.
  - Latency: exactly 1 cycle from accept to ex_valid.
- Hold: while ex_valid && !ex_ready, all ex_* outputs stay bit-stable. Forwarding updates during the hold are not re-sampled.
- Consume without new accept: ex_valid falls to 0.
- Consume with accept in the same cycle: the new op loads; ex_valid stays 1.
- Hazard present, ex side free: a bubble is inserted (ex_valid=0) and id_ready=0. Decode re-presents the same op next cycle.
- flush:
  - Next cycle ex_valid=0 regardless of ex_ready.
  - id_ready is still driven as above, but any accepted op is dropped.
  - Data registers may keep their stale values.
  - flush wins over capture.
- Data registers update only on capture. ex_valid is the sole control flop.

Optional Feature:
- ALU_OPERAND_PERF_EN defined:
  - Adds output ports perf_stall_cnt (32) and perf_bubble_cnt (32), both reset to 0.
  - stall counts cycles with id_valid && !id_ready.
  - bubble counts cycles where hz forced ex_valid=0.
  - Both saturate at 32'hFFFFFFFF.
  - flush does not clear them.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - alucontrol codes ALU_MOV 00000, ADD 00001, SUB 00010, AND 00011, OR 00100, XOR 00101, SLL 00110, SRL 00111, SRA 01000, EQ 01001, NE 01010, LTU 01011, GTU 01100, GEU 01101, LT 01110, GT 01111, GE 10000, LUI 10001.
  - XLEN and REG_AW defaults.
  - Packed struct op_t holding alucontrol, rd_addr, wb_en and mem_read.
- One sub-module, fwd_mux: per-operand priority forwarding, instantiated twice (srca, srcb).

Test Plan:
- Reset mid-hold: with ex_valid=1 and ex_ready=0, assert rst → ex_valid=0 and ex_alucontrol=0 immediately; first op after deassert issues 1 cycle after accept.
- ADD with rs=3 (rf 5), rd=4 (rf 7), mem_fwd_en addr 3 data 9, wb_fwd_en addr 3 data 11 → ex_srca=9 (MEM over WB), ex_srcb=7.
- rs=0 with mem_fwd_en addr 0 data 0xDEAD → ex_srca=0; use_imm=1, imm=0x10, MEM load on rs → no stall, ex_srca=0x10.
- Load-use: mem_fwd_is_load, addr 4 = rd → id_ready=0 and one bubble; next cycle WB match data 0x55 → accepted, ex_srcb=0x55.
- Backpressure: ex_ready=0 for 3 cycles with id_valid=1 → ex_* stable, id_ready=0. Then ex_ready=1 → new op loads the same cycle and ex_valid stays 1.
- flush together with id_valid=1 and ex_valid=1 → next cycle ex_valid=0; with ALU_OPERAND_PERF_EN, counters match the cycles counted.
